subneg_ctrl_hs: RTL and testbench

Parametrised multi-cycle control unit for the SUBNEG/SUBLEQ processor. It sequences a full instruction: fetch A, B and C, read mem[A] and mem[B], write mem[B]-mem[A], then branch. Every memory access uses a req/ack handshake, so memory may insert any number of wait states. It also adds a selectable branch condition, single-step mode, self-loop halt and a retired-instruction counter. The datapath (PC, A/B/C, operand registers, subtractor) is external; this block drives only strobes and selects.

---
 rtl/subneg_pkg.sv | 42 ++++
 rtl/subneg_ctrl_hs_sat_cnt.sv | 22 ++
 rtl/subneg_ctrl_hs.sv | 111 +++++++++++
 tb/tb_subneg_ctrl_hs.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/subneg_pkg.sv
// Shared types and constants for the SUBNEG/SUBLEQ control unit.
//   state_t       : controller state encoding
//   ADDR_*        : memory address mux selects driven on addr_sel
//   MODE_*        : branch-condition selection for the MODE parameter
//   is_mem_state  : 1 for states that own a memory handshake
//   addr_of       : address mux select for a given state
package subneg_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH_A = 4'd1,
    S_FETCH_B = 4'd2,
    S_FETCH_C = 4'd3,
    S_READ_A  = 4'd4,
    S_READ_B  = 4'd5,
    S_WRITE_B = 4'd6,
    S_BRANCH  = 4'd7,
    S_PAUSE   = 4'd8,
    S_HALT    = 4'd9
  } state_t;

  localparam logic [1:0] ADDR_PC = 2'd0;
  localparam logic [1:0] ADDR_A  = 2'd1;
  localparam logic [1:0] ADDR_B  = 2'd2;

  localparam int MODE_SUBNEG = 0;
  localparam int MODE_SUBLEQ = 1;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH_A) || (s == S_FETCH_B) || (s == S_FETCH_C) ||
           (s == S_READ_A)  || (s == S_READ_B)  || (s == S_WRITE_B);
  endfunction

  function automatic logic [1:0] addr_of(input state_t s);
    case (s)
      S_READ_A:           return ADDR_A;
      S_READ_B, S_WRITE_B: return ADDR_B;
      default:            return ADDR_PC;
    endcase
  endfunction

endpackage

// File: rtl/subneg_ctrl_hs_sat_cnt.sv
// Saturating up-counter used for the retired-instruction count.
//   clk   : clock
//   rst_n : synchronous active-low reset (clears value)
//   inc   : count one event this cycle
//   value : current count, sticks at all-ones
module subneg_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (!rst_n)
      value <= '0;
    else if (inc && (value != '1))
      value <= value + W'(1);
  end

endmodule

// File: rtl/subneg_ctrl_hs.sv
// Multi-cycle controller for a SUBNEG/SUBLEQ core. Sequences
// fetch A/B/C, read mem[A], read mem[B], write mem[B]-mem[A], branch.
// Every memory access is a req/ack handshake with arbitrary wait states.
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : leave IDLE
//   step_en, step     : single-step control (PAUSE after each instruction)
//   mem_ack           : memory completes current access this cycle
//   neg, zero         : datapath result flags (valid in WRITE_B/BRANCH)
//   self_loop         : C equals the instruction start address
//   mem_req, mem_we   : memory request / write qualifier (registered)
//   addr_sel          : address mux select (registered, ADDR_* constants)
//   ld_a/b/c, ld_opa/opb, pc_inc, pc_we : datapath strobes (combinational)
//   busy, halted      : status (registered)
//   instr_cnt         : retired instructions, saturating
module subneg_ctrl_hs
  import subneg_pkg::*;
#(
  parameter int MODE         = MODE_SUBNEG,
  parameter int HALT_ON_SELF = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_en,
  input  logic             step,
  input  logic             mem_ack,
  input  logic             neg,
  input  logic             zero,
  input  logic             self_loop,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       addr_sel,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_c,
  output logic             ld_opa,
  output logic             ld_opb,
  output logic             pc_inc,
  output logic             pc_we,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t state;
  state_t state_nxt;
  logic   taken;

  assign taken = (MODE == MODE_SUBLEQ) ? (neg | zero) : neg;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start)   state_nxt = S_FETCH_A;
      S_FETCH_A: if (mem_ack) state_nxt = S_FETCH_B;
      S_FETCH_B: if (mem_ack) state_nxt = S_FETCH_C;
      S_FETCH_C: if (mem_ack) state_nxt = S_READ_A;
      S_READ_A:  if (mem_ack) state_nxt = S_READ_B;
      S_READ_B:  if (mem_ack) state_nxt = S_WRITE_B;
      S_WRITE_B: if (mem_ack) state_nxt = S_BRANCH;
      S_BRANCH: begin
        if (taken && self_loop && (HALT_ON_SELF != 0)) state_nxt = S_HALT;
        else if (step_en)                              state_nxt = S_PAUSE;
        else                                           state_nxt = S_FETCH_A;
      end
      // Dropping step_en releases a paused core just like a step pulse.
      S_PAUSE:   if (step || !step_en) state_nxt = S_FETCH_A;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they are
  // registered yet line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      addr_sel <= ADDR_PC;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      mem_req  <= is_mem_state(state_nxt);
      mem_we   <= (state_nxt == S_WRITE_B);
      addr_sel <= addr_of(state_nxt);
      busy     <= !((state_nxt == S_IDLE) || (state_nxt == S_PAUSE) ||
                    (state_nxt == S_HALT));
      halted   <= (state_nxt == S_HALT);
    end
  end

  // Load strobes fire only in the ack cycle of their access.
  assign ld_a   = (state == S_FETCH_A) && mem_ack;
  assign ld_b   = (state == S_FETCH_B) && mem_ack;
  assign ld_c   = (state == S_FETCH_C) && mem_ack;
  assign ld_opa = (state == S_READ_A)  && mem_ack;
  assign ld_opb = (state == S_READ_B)  && mem_ack;
  assign pc_inc = ld_a || ld_b || ld_c;
  assign pc_we  = (state == S_BRANCH) && taken;

  subneg_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state == S_BRANCH),
    .value (instr_cnt)
  );

endmodule

// File: tb/tb_subneg_ctrl_hs.sv
module tb_subneg_ctrl_hs;
  import subneg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, step_en, step, mem_ack, neg, zero, self_loop;

  // u0: SUBNEG, 16-bit counter.  u1: SUBLEQ, 2-bit counter. Shared stimulus.
  logic mem_req0, mem_we0, ld_a0, ld_b0, ld_c0, ld_opa0, ld_opb0, pc_inc0, pc_we0, busy0, halted0;
  logic [1:0]  addr_sel0;
  logic [15:0] cnt0;
  logic mem_req1, mem_we1, ld_a1, ld_b1, ld_c1, ld_opa1, ld_opb1, pc_inc1, pc_we1, busy1, halted1;
  logic [1:0]  addr_sel1;
  logic [1:0]  cnt1;

  subneg_ctrl_hs #(.MODE(MODE_SUBNEG), .HALT_ON_SELF(1), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .step_en(step_en), .step(step),
    .mem_ack(mem_ack), .neg(neg), .zero(zero), .self_loop(self_loop),
    .mem_req(mem_req0), .mem_we(mem_we0), .addr_sel(addr_sel0),
    .ld_a(ld_a0), .ld_b(ld_b0), .ld_c(ld_c0), .ld_opa(ld_opa0), .ld_opb(ld_opb0),
    .pc_inc(pc_inc0), .pc_we(pc_we0), .busy(busy0), .halted(halted0), .instr_cnt(cnt0));

  subneg_ctrl_hs #(.MODE(MODE_SUBLEQ), .HALT_ON_SELF(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .step_en(step_en), .step(step),
    .mem_ack(mem_ack), .neg(neg), .zero(zero), .self_loop(self_loop),
    .mem_req(mem_req1), .mem_we(mem_we1), .addr_sel(addr_sel1),
    .ld_a(ld_a1), .ld_b(ld_b1), .ld_c(ld_c1), .ld_opa(ld_opa1), .ld_opb(ld_opb1),
    .pc_inc(pc_inc1), .pc_we(pc_we1), .busy(busy1), .halted(halted1), .instr_cnt(cnt1));

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else npass++;
  endtask

  // Scoreboard of per-instruction expectations.
  typedef struct {
    logic we0;
    logic we1;
    int   lat;
    int   acyc;
  } exp_t;
  exp_t sb[$];

  // Memory responder: acks every cycle unless asked to delay READ_A or stall WRITE_B.
  logic delay_a  = 1'b0;
  logic stall_we = 1'b0;
  int   waited   = 0;
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_req0 && addr_sel0 == ADDR_A && delay_a && waited < 3) begin
        mem_ack = 1'b0;
        waited++;
      end else if (mem_req0 && mem_we0 && stall_we) begin
        mem_ack = 1'b0;
      end else begin
        mem_ack = 1'b1;
        if (mem_req0 && addr_sel0 == ADDR_A) waited = 0;
      end
    end
  end

  // Monitor: BRANCH is the only busy cycle without a memory request.
  int busy_cyc = 0, pinc = 0, ldabc = 0, opa = 0, opb = 0, acyc = 0, wecyc = 0, br_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n || !busy0) begin
      busy_cyc = 0; pinc = 0; ldabc = 0; opa = 0; opb = 0; acyc = 0; wecyc = 0;
      if (pc_we0 === 1'b1) begin ntot++; $display("FAIL pc_we_idle: got 1 expected 0"); end
    end else begin
      busy_cyc++;
      if (pc_inc0) pinc++;
      if (ld_a0) ldabc++;
      if (ld_b0) ldabc++;
      if (ld_c0) ldabc++;
      if (ld_opa0) opa++;
      if (ld_opb0) opb++;
      if (mem_req0 && addr_sel0 == ADDR_A) acyc++;
      if (mem_we0) wecyc++;
      if (!mem_req0) begin
        br_cnt++;
        if (sb.size() == 0) begin
          ntot++;
          $display("FAIL sb_underflow: got branch expected none");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", busy_cyc, e.lat);
          chk("pc_inc_pulses", pinc, 3);
          chk("ld_abc_pulses", ldabc, 3);
          chk("ld_opa_pulses", opa, 1);
          chk("ld_opb_pulses", opb, 1);
          chk("read_a_cycles", acyc, e.acyc);
          chk("we_cycles", wecyc, 1);
          chk("pc_we_mode0", pc_we0, e.we0);
          chk("pc_we_mode1", pc_we1, e.we1);
        end
        busy_cyc = 0; pinc = 0; ldabc = 0; opa = 0; opb = 0; acyc = 0; wecyc = 0;
      end else if (pc_we0) begin
        ntot++;
        $display("FAIL pc_we_mem: got 1 expected 0");
      end
    end
  end

  // Drive flags for one instruction, queue its expectation, wait for its BRANCH.
  task automatic run_instr(input logic n, input logic z, input logic sl,
                           input logic w0, input logic w1, input int lat, input int ac);
    exp_t e;
    int   b;
    bit   seen;
    e.we0 = w0; e.we1 = w1; e.lat = lat; e.acyc = ac;
    sb.push_back(e);
    neg = n; zero = z; self_loop = sl;
    b = br_cnt;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (br_cnt != b) seen = 1;
    end
    if (!seen) begin
      ntot++;
      $display("FAIL branch_timeout: got no branch expected one within 60 cycles");
    end
  endtask

  typedef struct {
    logic n, z, sl;
    logic w0, w1;
  } vec_t;
  vec_t tbl[5];

  initial begin
    // neg zero self_loop | pc_we SUBNEG, pc_we SUBLEQ
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 0; start = 0; step_en = 0; step = 0; neg = 0; zero = 0; self_loop = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req0, 0);
    chk("rst_mem_we", mem_we0, 0);
    chk("rst_addr_sel", addr_sel0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_halted", halted0, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("idle_no_start", {busy0, mem_req0}, 2'b00);

    // Zero-wait free run over the vector table.
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("start_fetch_a", {busy0, mem_req0, addr_sel0}, 4'b1100);
    for (int i = 0; i < 5; i++) begin
      run_instr(tbl[i].n, tbl[i].z, tbl[i].sl, tbl[i].w0, tbl[i].w1, 7, 1);
      if (i == 0) begin
        chk("cnt_after_first", cnt0, 1);
        chk("back_to_fetch_a", {busy0, mem_req0, addr_sel0}, 4'b1100);
      end
    end
    chk("cnt0_five", cnt0, 5);
    chk("cnt1_saturated", cnt1, 3);

    // Three wait states on READ_A.
    delay_a = 1;
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 4);
    delay_a = 0;

    // Single step.
    step_en = 1;
    run_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7, 1);
    for (int i = 0; i < 5; i++) begin
      chk("pause_hold", {busy0, mem_req0, halted0}, 3'b000);
      @(posedge clk); #1;
    end
    step = 1;
    @(posedge clk); #1;
    step = 0;
    chk("step_fetch_a", {busy0, mem_req0, addr_sel0}, 4'b1100);
    run_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7, 1);
    chk("paused_again", {busy0, mem_req0}, 2'b00);
    step_en = 0;
    @(posedge clk); #1;
    chk("step_en_drop_fetch_a", {busy0, mem_req0, addr_sel0}, 4'b1100);
    chk("cnt0_eight", cnt0, 8);

    // Self-loop halt.
    run_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 7, 1);
    neg = 0; self_loop = 0;
    chk("halted0", halted0, 1);
    chk("halted1", halted1, 1);
    start = 1;
    for (int i = 0; i < 4; i++) begin
      chk("halt_absorb", {busy0, mem_req0, halted0}, 3'b001);
      @(posedge clk); #1;
    end
    start = 0;
    chk("cnt0_nine", cnt0, 9);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("halt_rst_halted", halted0, 0);
    chk("halt_rst_cnt0", cnt0, 0);
    chk("halt_rst_cnt1", cnt1, 0);

    // Reset in the middle of a stalled WRITE_B.
    stall_we = 1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk); #1;
        if (mem_we0) seen = 1;
      end
      if (!seen) begin
        ntot++;
        $display("FAIL write_b_timeout: got no mem_we expected one within 20 cycles");
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("write_b_held", {mem_req0, mem_we0, addr_sel0}, 4'b1110);
    rst_n = 0;
    @(posedge clk); #1;
    chk("rst_mid_we", {mem_req0, mem_we0, busy0}, 3'b000);
    rst_n = 1;
    stall_we = 0;
    @(posedge clk); #1;
    chk("idle_after_rst", {busy0, mem_req0}, 2'b00);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
